// File: rtl/zd_pipe_pkg.sv
// Shared definitions for the frame scheduler: state encoding, stage codes and
// the default frame geometry / pipeline latencies.
package zd_pipe_pkg;

  localparam int unsigned IMG_SIZE_DEF = 900;
  localparam int unsigned RD_LAT_DEF   = 3;
  localparam int unsigned PROC_LAT_DEF = 2;
  localparam int unsigned CNT_W        = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    STG_BLUR   = 2'd0,
    STG_DILATE = 2'd1,
    STG_ERODE  = 2'd2
  } stage_e;

endpackage

// File: rtl/zd_sched_xfer_cnt.sv
// Transfer counter: counts issued words, delays each issue by RD_LAT or PROC_LAT
// and produces the matching stage-buffer write strobe and address. Latencies >= 1.
module zd_sched_xfer_cnt
  import zd_pipe_pkg::*;
#(
  parameter int unsigned IMG_SIZE = IMG_SIZE_DEF,
  parameter int unsigned RD_LAT   = RD_LAT_DEF,
  parameter int unsigned PROC_LAT = PROC_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_issue,
  input  logic             i_proc_lat,
  output logic             o_issue_done,
  output logic             o_issue_last,
  output logic             o_we,
  output logic             o_we_last,
  output logic [CNT_W-1:0] o_wr_addr
);

  localparam int unsigned MAX_LAT = (RD_LAT > PROC_LAT) ? RD_LAT : PROC_LAT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_SIZE - 1);

  logic [CNT_W-1:0]   r_iss_cnt;
  logic               r_iss_done;
  logic [CNT_W-1:0]   r_wr_addr;
  logic [MAX_LAT-1:0] r_dly;
  logic               w_tap;

  always_comb begin
    w_tap = i_proc_lat ? r_dly[PROC_LAT-1] : r_dly[RD_LAT-1];
  end

  // The issue counter parks at LAST and raises a done flag instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_cnt  <= '0;
      r_iss_done <= 1'b0;
      r_wr_addr  <= '0;
      r_dly      <= '0;
    end else if (i_clr) begin
      r_iss_cnt  <= '0;
      r_iss_done <= 1'b0;
      r_wr_addr  <= '0;
      r_dly      <= '0;
    end else begin
      r_dly <= (r_dly << 1) | MAX_LAT'(i_issue);
      if (i_issue && !r_iss_done) begin
        if (r_iss_cnt == LAST) r_iss_done <= 1'b1;
        else                   r_iss_cnt  <= r_iss_cnt + 1'b1;
      end
      if (w_tap && (r_wr_addr != LAST)) r_wr_addr <= r_wr_addr + 1'b1;
    end
  end

  assign o_issue_done = r_iss_done;
  assign o_issue_last = i_issue && !r_iss_done && (r_iss_cnt == LAST);
  assign o_we         = w_tap;
  assign o_we_last    = w_tap && (r_wr_addr == LAST);
  assign o_wr_addr    = r_wr_addr;

endmodule

// File: rtl/zd_frame_sched.sv
// Frame scheduler: loads a frame, runs blur/dilate/erode stages, drains it.
// Define ZD_SCHED_PERF_EN to add the frame_cycles performance counter output.
module zd_frame_sched
  import zd_pipe_pkg::*;
#(
  parameter int unsigned IMG_SIZE = IMG_SIZE_DEF,
  parameter int unsigned RD_LAT   = RD_LAT_DEF,
  parameter int unsigned PROC_LAT = PROC_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [10:0]  src_fifo_data_count,
  input  logic         src_fifo_empty,
  output logic         src_fifo_rd_en,
  input  logic         dst_fifo_full,
  output logic         dst_fifo_wr_en,
  output logic         buf_we,
  output logic [9:0]   wr_addr,
  output logic         addr_gen_en,
  output logic [1:0]   stage_sel,
  output logic         buf_sel,
  output logic         frame_done,
  output logic         busy,
  output logic         underrun,
  output sched_state_e dbg_state
`ifdef ZD_SCHED_PERF_EN
  ,
  output logic [31:0]  frame_cycles
`endif
);

  sched_state_e     r_state, w_next;
  stage_e           r_stage;
  logic             r_buf_sel, r_underrun;
  logic             w_issue, w_proc_lat, w_clr, w_stage_end;
  logic             w_iss_done, w_iss_last, w_we, w_we_last;
  logic [CNT_W-1:0] w_wr_addr;

  // Counters restart on every stage boundary and whenever no frame is active.
  assign w_stage_end = w_we_last && ((r_state == ST_LOAD) || (r_state == ST_PROC));
  assign w_clr       = (r_state == ST_IDLE) || (r_state == ST_DONE) || w_stage_end;

  zd_sched_xfer_cnt #(
    .IMG_SIZE (IMG_SIZE),
    .RD_LAT   (RD_LAT),
    .PROC_LAT (PROC_LAT)
  ) u_xfer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_clr),
    .i_issue      (w_issue),
    .i_proc_lat   (w_proc_lat),
    .o_issue_done (w_iss_done),
    .o_issue_last (w_iss_last),
    .o_we         (w_we),
    .o_we_last    (w_we_last),
    .o_wr_addr    (w_wr_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    src_fifo_rd_en = 1'b0;
    addr_gen_en    = 1'b0;
    dst_fifo_wr_en = 1'b0;
    buf_we         = 1'b0;
    w_issue        = 1'b0;
    w_proc_lat     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((src_fifo_data_count >= 11'(IMG_SIZE)) && !dst_fifo_full) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        src_fifo_rd_en = !src_fifo_empty && !w_iss_done;
        w_issue        = src_fifo_rd_en;
        buf_we         = w_we;
        if (w_we_last) w_next = ST_PROC;
      end
      ST_PROC: begin
        addr_gen_en = !w_iss_done;
        w_issue     = addr_gen_en;
        w_proc_lat  = 1'b1;
        buf_we      = w_we;
        if (w_we_last && (r_stage == STG_ERODE)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        dst_fifo_wr_en = !dst_fifo_full && !w_iss_done;
        w_issue        = dst_fifo_wr_en;
        if (w_iss_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage    <= STG_BLUR;
      r_buf_sel  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_stage <= STG_BLUR;
      else if ((r_state == ST_PROC) && w_we_last)
        r_stage <= (r_stage == STG_ERODE) ? STG_BLUR : stage_e'(r_stage + 2'd1);
      if (r_state == ST_DONE) r_buf_sel <= ~r_buf_sel;
      if ((r_state == ST_LOAD) && src_fifo_empty && !w_iss_done) r_underrun <= 1'b1;
    end
  end

  assign wr_addr    = w_wr_addr;
  assign stage_sel  = r_stage;
  assign buf_sel    = r_buf_sel;
  assign underrun   = r_underrun;
  assign frame_done = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

`ifdef ZD_SCHED_PERF_EN
  logic [31:0] r_cyc, r_frame_cycles;

  // Counts LOAD..DRAIN cycles; the latched value also includes the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc          <= '0;
      r_frame_cycles <= '0;
    end else begin
      if ((r_state == ST_IDLE) || (r_state == ST_DONE)) r_cyc <= '0;
      else if (r_cyc != '1)                             r_cyc <= r_cyc + 1'b1;
      if (r_state == ST_DONE)
        r_frame_cycles <= (r_cyc == '1) ? r_cyc : r_cyc + 1'b1;
    end
  end

  assign frame_cycles = r_frame_cycles;
`endif

endmodule

// File: tb/tb_zd_frame_sched.sv
// Self-checking bench for zd_frame_sched: cycle-accurate expectations for every
// handshake output, with stage-buffer writes checked through an expected queue.
`timescale 1ns/1ps
module tb_zd_frame_sched;
  import zd_pipe_pkg::*;

  localparam int IMG   = 900;
  localparam int RDL   = 3;
  localparam int PRL   = 2;
  localparam int W     = 44;          // {due cycle[31:0], wr_addr[9:0], stage[1:0]}
  localparam int BIG   = 32'h3fff_ffff;
  localparam int T_MAX = 7000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [10:0]  src_fifo_data_count = '0;
  logic         src_fifo_empty = 1'b0;
  logic         dst_fifo_full = 1'b0;
  logic         src_fifo_rd_en, dst_fifo_wr_en, buf_we, addr_gen_en;
  logic [9:0]   wr_addr;
  logic [1:0]   stage_sel;
  logic         buf_sel, frame_done, busy, underrun;
  sched_state_e dbg_state;
`ifdef ZD_SCHED_PERF_EN
  logic [31:0]  frame_cycles;
`endif

  logic [19:0] all_outs;
  assign all_outs = {src_fifo_rd_en, dst_fifo_wr_en, buf_we, wr_addr, addr_gen_en,
                     stage_sel, buf_sel, frame_done, busy, underrun};

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  zd_frame_sched dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .src_fifo_data_count (src_fifo_data_count),
    .src_fifo_empty      (src_fifo_empty),
    .src_fifo_rd_en      (src_fifo_rd_en),
    .dst_fifo_full       (dst_fifo_full),
    .dst_fifo_wr_en      (dst_fifo_wr_en),
    .buf_we              (buf_we),
    .wr_addr             (wr_addr),
    .addr_gen_en         (addr_gen_en),
    .stage_sel           (stage_sel),
    .buf_sel             (buf_sel),
    .frame_done          (frame_done),
    .busy                (busy),
    .underrun            (underrun),
    .dbg_state           (dbg_state)
`ifdef ZD_SCHED_PERF_EN
    ,
    .frame_cycles        (frame_cycles)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0;
    src_fifo_data_count = '0;
    src_fifo_empty = 1'b0;
    dst_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", all_outs);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
`ifdef ZD_SCHED_PERF_EN
    checks++;
    if (frame_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_frame_cycles got %0d exp 0", frame_cycles);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if ((busy !== 1'b0) || (dbg_state !== ST_IDLE)) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b state=%0d exp busy=0 state=0", busy, dbg_state);
    end
  endtask

  // One complete frame; the bench predicts every cycle of every output.
  task automatic test_frame(input int empty_len, input int full_len,
                            input logic exp_underrun, input string tag);
    int t, reads, gen_in_stage, stage_m, wtotal, pushes;
    int t_gen_start, t_drain, t_done;
    logic empty_d, full_d, exp_rd, exp_gen, exp_wr, exp_we, exp_busy, exp_done, start_sel;
    logic [W-1:0] e;
    start_sel = buf_sel;
    exp_q.delete();
    t = 0; reads = 0; gen_in_stage = 0; stage_m = 0; wtotal = 0; pushes = 0;
    t_gen_start = BIG; t_drain = BIG; t_done = BIG;
    while ((t <= t_done + 1) && (t < T_MAX)) begin
      @(posedge clk);
      #1;
      empty_d = (t >= 401) && (t < 401 + empty_len);
      full_d  = (t_drain != BIG) && (t >= t_drain + 50) && (t < t_drain + 50 + full_len);
      src_fifo_data_count = (t == 0) ? 11'd900 : 11'd0;
      src_fifo_empty = empty_d;
      dst_fifo_full  = full_d;
      #1;
      exp_rd   = (t >= 1) && (reads < IMG) && !empty_d;
      exp_gen  = (t >= t_gen_start) && (gen_in_stage < IMG);
      exp_wr   = (t >= t_drain) && (pushes < IMG) && !full_d;
      exp_we   = (exp_q.size() > 0) && (exp_q[0][W-1:12] == 32'(t));
      exp_busy = (t >= 1) && (t <= t_done);
      exp_done = (t == t_done);

      checks++;
      if (src_fifo_rd_en !== exp_rd) begin
        errors++;
        $display("FAIL %s rd_en t=%0d got %b exp %b", tag, t, src_fifo_rd_en, exp_rd);
      end
      checks++;
      if (addr_gen_en !== exp_gen) begin
        errors++;
        $display("FAIL %s addr_gen_en t=%0d got %b exp %b", tag, t, addr_gen_en, exp_gen);
      end
      checks++;
      if (dst_fifo_wr_en !== exp_wr) begin
        errors++;
        $display("FAIL %s wr_en t=%0d got %b exp %b", tag, t, dst_fifo_wr_en, exp_wr);
      end
      checks++;
      if ((busy !== exp_busy) || (frame_done !== exp_done)) begin
        errors++;
        $display("FAIL %s busy_done t=%0d got %b%b exp %b%b", tag, t, busy, frame_done,
                 exp_busy, exp_done);
      end
      if (exp_gen) begin
        checks++;
        if (stage_sel !== 2'(stage_m)) begin
          errors++;
          $display("FAIL %s gen_stage t=%0d got %0d exp %0d", tag, t, stage_sel, stage_m);
        end
      end

      checks++;
      if (exp_we) begin
        e = exp_q.pop_front();
        if ((buf_we !== 1'b1) || (wr_addr !== e[11:2]) || (stage_sel !== e[1:0])) begin
          errors++;
          $display("FAIL %s buf_we t=%0d got we=%b addr=%0d stg=%0d exp we=1 addr=%0d stg=%0d",
                   tag, t, buf_we, wr_addr, stage_sel, e[11:2], e[1:0]);
        end
        wtotal++;
        if ((wtotal % IMG) == 0) begin
          if (wtotal < 4 * IMG) begin
            t_gen_start = t + 1;
            gen_in_stage = 0;
            stage_m = wtotal / IMG - 1;
          end else begin
            t_drain = t + 1;
          end
        end
      end else if (buf_we !== 1'b0) begin
        errors++;
        $display("FAIL %s buf_we t=%0d got 1 exp 0", tag, t);
      end

      if (exp_rd) begin
        exp_q.push_back({32'(t + RDL), 10'(reads), 2'd0});
        reads++;
      end
      if (exp_gen) begin
        exp_q.push_back({32'(t + PRL), 10'(gen_in_stage), 2'(stage_m)});
        gen_in_stage++;
      end
      if (exp_wr) begin
        pushes++;
        if (pushes == IMG) t_done = t + 1;
      end
      t++;
    end
    checks++;
    if (t >= T_MAX) begin
      errors++;
      $display("FAIL %s timeout t=%0d exp frame end before %0d", tag, t, T_MAX);
    end
    checks++;
    if (underrun !== exp_underrun) begin
      errors++;
      $display("FAIL %s underrun got %b exp %b", tag, underrun, exp_underrun);
    end
    checks++;
    if (buf_sel !== ~start_sel) begin
      errors++;
      $display("FAIL %s buf_sel got %b exp %b", tag, buf_sel, ~start_sel);
    end
`ifdef ZD_SCHED_PERF_EN
    checks++;
    if (frame_cycles !== 32'((IMG + RDL) + 3 * (IMG + PRL) + IMG + 1 + empty_len + full_len)) begin
      errors++;
      $display("FAIL %s frame_cycles got %0d exp %0d", tag, frame_cycles,
               (IMG + RDL) + 3 * (IMG + PRL) + IMG + 1 + empty_len + full_len);
    end
`endif
  endtask

  task automatic test_back_to_back;
    test_frame(0, 0, 1'b0, "b2b_0");
    test_frame(0, 0, 1'b0, "b2b_1");
  endtask

  task automatic test_stalls;
    test_frame(5, 10, 1'b1, "stall");
  endtask

  task automatic test_mid_reset;
    int t, reads;
    t = 0;
    reads = 0;
    while ((reads < 400) && (t < 2000)) begin
      @(posedge clk);
      #1;
      src_fifo_data_count = (t == 0) ? 11'd900 : 11'd0;
      src_fifo_empty = 1'b0;
      dst_fifo_full  = 1'b0;
      #1;
      if (src_fifo_rd_en === 1'b1) reads++;
      t++;
    end
    checks++;
    if (reads != 400) begin
      errors++;
      $display("FAIL mid_reset_reads got %0d exp 400", reads);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ((all_outs !== '0) || (dbg_state !== ST_IDLE)) begin
      errors++;
      $display("FAIL mid_reset_outs got %h state=%0d exp 0 state=0", all_outs, dbg_state);
    end
`ifdef ZD_SCHED_PERF_EN
    checks++;
    if (frame_cycles !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_frame_cycles got %0d exp 0", frame_cycles);
    end
`endif
    src_fifo_data_count = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ((all_outs !== '0) || (dbg_state !== ST_IDLE)) begin
      errors++;
      $display("FAIL mid_reset_release got %h state=%0d exp 0 state=0", all_outs, dbg_state);
    end
    test_frame(0, 0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stalls();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
